// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache refills and D-cache refills/writes onto one
// word-wide memory port. Refills are LINE_WORDS beats paced by mem_ack, and
// D-side writes are a single beat.
// Build option: MEM_ARB_ROUND_ROBIN_EN -- when defined, simultaneous requests
// alternate between sides. When undefined, the D-side always wins a tie.
module mem_arbiter #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          i_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] i_widx,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [31:0]                   d_wdata,
    output logic                          d_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] d_widx,
    output logic                          d_done,
    output logic [31:0]                   rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata,
    input  logic                          mem_ack
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = IDX_W + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IREAD  = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_beat;
    logic [IDX_W-1:0]    w_beat_nxt;
    logic                w_mem_req_nxt;
    logic                w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [31:0]         w_mem_wdata_nxt;
    logic                w_i_done_nxt;
    logic                w_d_done_nxt;
    logic                w_pick_d;
    logic                w_any_req;
    logic                w_unused_addr_bits;

    // Byte-offset bits below the line/word boundary never reach the memory port
    assign w_unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[1:0]};

    assign w_any_req = i_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;

    // Tie goes to the side not served by the previous grant
    assign w_pick_d = d_req & ~(i_req & r_last_d);

    // Last-grant pointer, updated at every grant; resets to the I-side
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && w_any_req) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // D-side has fixed priority
    assign w_pick_d = d_req;
`endif

    // Per-side read handshake and pass-through of memory data
    assign i_rvalid = (r_state == IREAD) & mem_ack;
    assign d_rvalid = (r_state == DREAD) & mem_ack;
    assign i_widx   = r_beat;
    assign d_widx   = r_beat;
    assign rdata    = mem_rdata;

    // State and registered memory-port / done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            mem_req   <= w_mem_req_nxt;
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            i_done    <= w_i_done_nxt;
            d_done    <= w_d_done_nxt;
        end
    end

    // Next-state and next-output logic; arbitration happens only in IDLE
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat;
        w_mem_req_nxt   = mem_req;
        w_mem_we_nxt    = mem_we;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_i_done_nxt    = 1'b0;
        w_d_done_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_mem_req_nxt = 1'b1;
                    w_beat_nxt    = '0;
                    if (w_pick_d) begin
                        if (d_we) begin
                            w_state_nxt     = DWRITE;
                            w_mem_we_nxt    = 1'b1;
                            w_mem_addr_nxt  = {d_addr[ADDR_W-1:2], 2'b00};
                            w_mem_wdata_nxt = d_wdata;
                        end else begin
                            w_state_nxt    = DREAD;
                            w_mem_addr_nxt = {d_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        end
                    end else begin
                        w_state_nxt    = IREAD;
                        w_mem_addr_nxt = {i_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    end
                end
            end

            IREAD, DREAD: begin
                if (mem_ack) begin
                    if (r_beat == IDX_W'(LINE_WORDS - 1)) begin
                        w_state_nxt   = DONE;
                        w_mem_req_nxt = 1'b0;
                        w_beat_nxt    = '0;
                        w_i_done_nxt  = (r_state == IREAD);
                        w_d_done_nxt  = (r_state == DREAD);
                    end else begin
                        w_beat_nxt     = r_beat + IDX_W'(1);
                        w_mem_addr_nxt = mem_addr + ADDR_W'(4);
                    end
                end
            end

            DWRITE: begin
                if (mem_ack) begin
                    w_state_nxt   = DONE;
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_d_done_nxt  = 1'b1;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter. The driver
// predicts every memory beat and done pulse from the arbitration and address
// rules and queues them, and an independent monitor pops and compares them.
module tb_mem_arbiter;

    localparam int unsigned LW = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = $clog2(LW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_rvalid;
    logic [IW-1:0] i_widx;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_rvalid;
    logic [IW-1:0] d_widx;
    logic          d_done;
    logic [31:0]   rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ack = 1'b0;

    mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_widx(i_widx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_widx(d_widx), .d_done(d_done),
        .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;
    } beat_t;

    beat_t       exp_q[$];
    bit          done_q[$];
    bit          obs_order[$];
    int          checks = 0;
    int          fails = 0;
    int          rv_count = 0;
    bit          mon_en = 1'b0;
    int          ack_mode = 0;
    int          pat_cnt = 0;
    bit          m_last_d = 1'b0;
    bit          pend_i = 1'b0;
    bit          pend_d = 1'b0;
    logic [31:0] cur_i_addr = '0;
    logic [31:0] cur_d_addr = '0;
    logic [31:0] cur_d_wdata = '0;
    bit          cur_d_we = 1'b0;
    int          last_lat = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    // Reference arbitration: ties follow the build option, pointer tracks every grant
    function automatic bit model_arb(input bit pi, input bit pd);
        bit win_d;
        if (pi && pd) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_d = !m_last_d;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = pd;
        end
        m_last_d = win_d;
        return win_d;
    endfunction

    function automatic void push_beats(input bit d, input bit we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input int n);
        beat_t       b;
        logic [31:0] base;
        if (we) begin
            b.d = 1'b1; b.we = 1'b1; b.addr = addr & ~32'd3; b.wdata = wdata; b.k = 0;
            exp_q.push_back(b);
        end else begin
            base = addr & ~(32'(LW * 4) - 32'd1);
            for (int k = 0; k < n; k++) begin
                b.d = d; b.we = 1'b0; b.addr = base + 32'(4 * k); b.wdata = '0; b.k = k;
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic void push_txn(input bit d);
        if (d) push_beats(1'b1, cur_d_we, cur_d_addr, cur_d_wdata, LW);
        else   push_beats(1'b0, 1'b0, cur_i_addr, '0, LW);
        done_q.push_back(d);
    endfunction

    task automatic raise_i(input logic [31:0] a);
        i_req = 1'b1; i_addr = a; cur_i_addr = a; pend_i = 1'b1;
    endtask

    task automatic raise_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        cur_d_we = we; cur_d_addr = a; cur_d_wdata = wd; pend_d = 1'b1;
    endtask

    task automatic wait_done(input bit d, output int lat);
        lat = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            lat++;
            if (d ? d_done : i_done) return;
        end
        checks++;
        fails++;
        $display("FAIL done_timeout: side %0d got no done within 300 cycles", d);
        finish_now();
    endtask

    // Serve all pending requests; a side may re-request in the IDLE cycle after its done
    task automatic run_until_idle(input int extra_i, input int extra_d);
        bit w;
        int lat;
        while (pend_i || pend_d) begin
            w = model_arb(pend_i, pend_d);
            push_txn(w);
            wait_done(w, lat);
            last_lat = lat;
            if (w) begin d_req = 1'b0; pend_d = 1'b0; end
            else   begin i_req = 1'b0; pend_i = 1'b0; end
            @(negedge clk);
            if (w && extra_d > 0) begin
                extra_d--;
                raise_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            end else if (!w && extra_i > 0) begin
                extra_i--;
                raise_i($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last_d = 1'b0;
        exp_q.delete();
        done_q.delete();
    endtask

    // Memory model: ack pattern per mode, fresh read data every cycle
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = ($urandom_range(0, 9) < 7);
            default: begin mem_ack = (pat_cnt % 3 == 0); pat_cnt++; end
        endcase
        mem_rdata = $urandom;
    end

    // Monitor: compare every beat and done pulse against the scoreboard
    initial begin
        beat_t b;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL stray_beat: addr 0x%0h with no expected beat", mem_addr);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_addr", mem_addr, b.addr);
                    chk("beat_we", 32'(mem_we), 32'(b.we));
                    if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
                    chk("i_rvalid", 32'(i_rvalid), 32'(!b.d && !b.we));
                    chk("d_rvalid", 32'(d_rvalid), 32'(b.d && !b.we));
                    if (b.d) chk("d_widx", 32'(d_widx), 32'(b.k));
                    else     chk("i_widx", 32'(i_widx), 32'(b.k));
                    if (i_rvalid || d_rvalid) chk("rdata", rdata, mem_rdata);
                end
            end else if (mem_req) begin
                if (exp_q.size() > 0) chk("addr_hold", mem_addr, exp_q[0].addr);
                chk("rvalid_no_ack", 32'({i_rvalid, d_rvalid}), 32'd0);
            end else if (mem_ack) begin
                chk("rvalid_idle_ack", 32'({i_rvalid, d_rvalid}), 32'd0);
            end
            if (i_rvalid || d_rvalid) rv_count++;
            if (i_done || d_done) begin
                chk("done_onehot", 32'(i_done && d_done), 32'd0);
                chk("req_low_in_done", 32'(mem_req), 32'd0);
                obs_order.push_back(d_done);
                if (done_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL stray_done: i_done %0d d_done %0d unexpected", i_done, d_done);
                end else begin
                    chk("done_side", 32'(d_done), 32'(done_q.pop_front()));
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int rv0;
        int gap;
        int lat;
        bit w;

        do_reset();
        mon_en = 1'b1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_i_done", 32'(i_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_i_widx", 32'(i_widx), 32'd0);
        chk("rst_d_widx", 32'(d_widx), 32'd0);

        // I refill with ack held high: done LINE_WORDS cycles after grant
        ack_mode = 0;
        rv0 = rv_count;
        raise_i(32'h0040_0014);
        run_until_idle(0, 0);
        chk("i_refill_latency", 32'(last_lat), 32'(LW + 1));
        chk("i_refill_valids", 32'(rv_count - rv0), 32'(LW));

        // Single D write
        ack_mode = 1;
        rv0 = rv_count;
        raise_d(1'b1, 32'h1000_0118, 32'd3);
        run_until_idle(0, 0);
        chk("d_write_no_rvalid", 32'(rv_count - rv0), 32'd0);

        // Tie after reset: D first, then build-dependent order with D re-requesting
        do_reset();
        obs_order.delete();
        raise_i($urandom);
        raise_d(1'b0, $urandom, 32'd0);
        run_until_idle(0, 1);
        chk("tie_count", 32'(obs_order.size()), 32'd3);
        if (obs_order.size() == 3) begin
            chk("tie_first_d", 32'(obs_order[0]), 32'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("tie_second", 32'(obs_order[1]), 32'd0);
`else
            chk("tie_second", 32'(obs_order[1]), 32'd1);
`endif
        end

        // D refill with sparse acks
        ack_mode = 2;
        pat_cnt = 0;
        rv0 = rv_count;
        raise_d(1'b0, 32'h3000_0110, 32'd0);
        run_until_idle(0, 0);
        chk("sparse_ack_valids", 32'(rv_count - rv0), 32'(LW));

        // Reset during beat 3 of an I refill
        ack_mode = 0;
        raise_i($urandom);
        push_beats(1'b0, 1'b0, cur_i_addr, '0, 4);
        repeat (4) @(negedge clk);
        rst = 1'b1; i_req = 1'b0; pend_i = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_i_done", 32'(i_done), 32'd0);
        chk("midrst_beats_seen", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        m_last_d = 1'b0;
        repeat (3) @(negedge clk);
        raise_d(1'b0, $urandom, 32'd0);
        run_until_idle(0, 0);

        // Requester holds req through done: next grant two cycles after done
        ack_mode = 1;
        raise_d(1'b0, $urandom, 32'd0);
        w = model_arb(1'b0, 1'b1);
        push_txn(w);
        wait_done(1'b1, lat);
        w = model_arb(1'b0, 1'b1);
        push_txn(w);
        gap = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            gap++;
            if (mem_req) break;
        end
        chk("hold_regrant_gap", 32'(gap), 32'd2);
        wait_done(1'b1, lat);
        d_req = 1'b0;
        pend_d = 1'b0;
        @(negedge clk);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            int sel;
            ack_mode = (n % 4 == 0) ? 0 : 1;
            sel = $urandom_range(1, 3);
            if (sel[0]) raise_i($urandom);
            if (sel[1]) raise_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            run_until_idle($urandom_range(0, 1), $urandom_range(0, 1));
        end

        repeat (4) @(negedge clk);
        chk("end_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("end_done_empty", 32'(done_q.size()), 32'd0);
        finish_now();
    end

endmodule
